// File: rtl/difftest_commit_sequencer_pkg.sv
// Record layout for the difftest instruction-commit port, with field extractors.
// Fields are packed LSB first: instr, pc, wdest, wpdest, special, fpwen, rfwen, isRVC, skip.
package difftest_commit_pkg;

    localparam int INSTR_LSB   = 0;
    localparam int INSTR_W     = 32;
    localparam int PC_LSB      = 32;
    localparam int PC_W        = 64;
    localparam int WDEST_LSB   = 96;
    localparam int WDEST_W     = 8;
    localparam int WPDEST_LSB  = 104;
    localparam int WPDEST_W    = 32;
    localparam int SPECIAL_LSB = 136;
    localparam int SPECIAL_W   = 8;
    localparam int FPWEN_BIT   = 144;
    localparam int RFWEN_BIT   = 145;
    localparam int ISRVC_BIT   = 146;
    localparam int SKIP_BIT    = 147;
    localparam int REC_W       = 148;

    typedef logic [REC_W-1:0] commit_rec_t;

    // A packed struct lists its members MSB first, so instr comes last.
    typedef struct packed {
        logic                 skip;
        logic                 is_rvc;
        logic                 rfwen;
        logic                 fpwen;
        logic [SPECIAL_W-1:0] special;
        logic [WPDEST_W-1:0]  wpdest;
        logic [WDEST_W-1:0]   wdest;
        logic [PC_W-1:0]      pc;
        logic [INSTR_W-1:0]   instr;
    } commit_fields_t;

    function automatic commit_rec_t pack_rec(input commit_fields_t f);
        return commit_rec_t'(f);
    endfunction

    function automatic logic [INSTR_W-1:0] rec_instr(input commit_rec_t r);
        return r[INSTR_LSB +: INSTR_W];
    endfunction

    function automatic logic [PC_W-1:0] rec_pc(input commit_rec_t r);
        return r[PC_LSB +: PC_W];
    endfunction

    function automatic logic [WDEST_W-1:0] rec_wdest(input commit_rec_t r);
        return r[WDEST_LSB +: WDEST_W];
    endfunction

    function automatic logic [WPDEST_W-1:0] rec_wpdest(input commit_rec_t r);
        return r[WPDEST_LSB +: WPDEST_W];
    endfunction

    function automatic logic [SPECIAL_W-1:0] rec_special(input commit_rec_t r);
        return r[SPECIAL_LSB +: SPECIAL_W];
    endfunction

    function automatic logic rec_fpwen(input commit_rec_t r);
        return r[FPWEN_BIT];
    endfunction

    function automatic logic rec_rfwen(input commit_rec_t r);
        return r[RFWEN_BIT];
    endfunction

    function automatic logic rec_is_rvc(input commit_rec_t r);
        return r[ISRVC_BIT];
    endfunction

    function automatic logic rec_skip(input commit_rec_t r);
        return r[SKIP_BIT];
    endfunction

endpackage

// File: rtl/difftest_commit_sequencer_if.sv
// Retire-side and sink-side signals of the commit sequencer.
// The slave modport is the sequencer's view; master is the view of the core/sink side.
interface difftest_commit_sequencer_if #(
    parameter int NUM_LANES = 2
);
    import difftest_commit_pkg::*;

    logic                         io_flush;
    logic [NUM_LANES-1:0]         io_in_valid;
    logic [NUM_LANES*REC_W-1:0]   io_in_rec;
    logic                         io_in_ready;
    logic                         io_out_valid;
    logic                         io_out_ready;
    commit_rec_t                  io_out_rec;
    logic [7:0]                   io_out_index;
    logic                         io_drop_err;
    logic [63:0]                  io_retired;

    modport master (
        output io_flush, io_in_valid, io_in_rec, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_rec, io_out_index, io_drop_err, io_retired
    );

    modport slave (
        input  io_flush, io_in_valid, io_in_rec, io_out_ready,
        output io_in_ready, io_out_valid, io_out_rec, io_out_index, io_drop_err, io_retired
    );

endinterface

// File: rtl/difftest_commit_compact.sv
// Lane compaction: each valid lane gets the number of valid lanes below it as its
// slot offset, and the enqueue count is the total number of valid lanes.
module difftest_commit_compact #(
    parameter  int NUM_LANES = 2,
    localparam int CNT_W     = $clog2(NUM_LANES + 1)
) (
    input  logic [NUM_LANES-1:0]            lane_valid,
    output logic [NUM_LANES-1:0][CNT_W-1:0] lane_slot,
    output logic [CNT_W-1:0]                enq_num
);

    always_comb begin
        logic [CNT_W-1:0] running;
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        running = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_slot[i] = running;
            running      = running + CNT_W'(lane_valid[i]);
        end
        enq_num = running;
    end

endmodule

// File: rtl/difftest_commit_sequencer.sv
// Buffers up to NUM_LANES retired records per cycle in program order and drains
// them one per cycle to the difftest commit port with a rolling 8-bit index.
module difftest_commit_sequencer
    import difftest_commit_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int DEPTH     = 8
) (
    input logic                         io_clock,
    input logic                         io_reset,
    difftest_commit_sequencer_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int CNT_W = $clog2(NUM_LANES + 1);

    commit_rec_t mem_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic [7:0]       index_q, index_d;
    logic [63:0]      retired_q, retired_d;
    logic             drop_q, drop_d;

    logic [NUM_LANES-1:0][CNT_W-1:0] lane_slot;
    logic [CNT_W-1:0]                enq_num;
    logic [NUM_LANES-1:0]            wr_en;
    logic [NUM_LANES-1:0][PTR_W-1:0] wr_addr;

    logic in_ready;
    logic out_valid;
    logic enq;
    logic deq;

    difftest_commit_compact #(.NUM_LANES(NUM_LANES)) u_compact (
        .lane_valid (bus.io_in_valid),
        .lane_slot  (lane_slot),
        .enq_num    (enq_num)
    );

    // Ready depends only on the registered count, so it never waits on the sink.
    assign in_ready  = (OCC_W'(DEPTH) - count_q) >= OCC_W'(NUM_LANES);
    assign out_valid = (count_q != '0);
    assign enq       = in_ready & ~bus.io_flush;
    assign deq       = out_valid & bus.io_out_ready & ~bus.io_flush;

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            wr_en[i]   = enq & bus.io_in_valid[i];
            wr_addr[i] = wr_ptr_q + PTR_W'(lane_slot[i]);
        end
    end

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        index_d   = index_q;
        retired_d = retired_q;
        drop_d    = drop_q | ((|bus.io_in_valid) & ~in_ready);
        if (bus.io_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(enq_num);
            end
            if (deq) begin
                rd_ptr_d  = rd_ptr_q + PTR_W'(1);
                index_d   = index_q + 8'd1;
                retired_d = retired_q + 64'd1;
            end
            count_d = count_q + (enq ? OCC_W'(enq_num) : OCC_W'(0)) - OCC_W'(deq);
        end
    end

    always_ff @(posedge io_clock or posedge io_reset) begin
        if (io_reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            index_q   <= '0;
            retired_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            index_q   <= index_d;
            retired_q <= retired_d;
            drop_q    <= drop_d;
        end
    end

    // NOTE: storage has no reset; count gates visibility, so stale slots are never presented.
    always_ff @(posedge io_clock) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (wr_en[i]) begin
                mem_q[wr_addr[i]] <= bus.io_in_rec[i*REC_W +: REC_W];
            end
        end
    end

    assign bus.io_in_ready  = in_ready;
    assign bus.io_out_valid = out_valid;
    assign bus.io_out_rec   = mem_q[rd_ptr_q];
    assign bus.io_out_index = index_q;
    assign bus.io_drop_err  = drop_q;
    assign bus.io_retired   = retired_q;

endmodule

// File: doc/difftest_commit_sequencer.md
Name: difftest_commit_sequencer

Overview:
- Collects up to NUM_LANES instruction-commit records per cycle from the core's retire stage and buffers them in program order.
- Drains them one per cycle into the single-record difftest instruction-commit port, stamping a rolling 8-bit index on each record.
- Sits between the core commit logic and the difftest commit sink; decouples multi-issue retire from the single-entry checker port.
- Provides backpressure, flush, a sticky drop-error flag and a retired-instruction counter.

Parameters:
- NUM_LANES, 2, commit lanes per cycle (1..4).
- DEPTH, 8, FIFO entries; power of two, must be >= 2*NUM_LANES.
- REC_W, 148, record width; fixed by the package layout, not overridable.

Ports:
- io_clock  in  1  clock.
- io_reset  in  1  asynchronous, active-high reset.
- io_flush  in  1  synchronous clear of buffered records.
- io_in_valid  in  NUM_LANES  per-lane commit valid.
- io_in_rec  in  NUM_LANES*REC_W  lane i occupies bits [i*REC_W +: REC_W].
- io_in_ready  out  1  all lanes may be accepted this cycle.
- io_out_valid  out  1  head record present.
- io_out_ready  in  1  sink accepts the head record.
- io_out_rec  out  REC_W  head record.
- io_out_index  out  8  sequence index of the head record.
- io_drop_err  out  1  sticky: a valid lane was presented while io_in_ready=0.
- io_retired  out  64  count of records dequeued since reset.

Behaviour:
- Reset values:
  - count = 0; read pointer = 0; write pointer = 0; index = 0; io_retired = 0; io_drop_err = 0.
  - io_out_valid = 0; io_in_ready = 1.
  - FIFO storage is not reset.
- io_in_ready = (DEPTH - count) >= NUM_LANES, computed from registered count only; it has no combinational path from io_out_ready.
- Enqueue happens when io_in_ready=1.
  - Valid lanes are compacted in ascending lane order into consecutive slots starting at the write pointer. Example: lanes {1,0} with only lane1 valid writes a single slot.
  - Write pointer advances by popcount(io_in_valid) modulo DEPTH.
- Dequeue fires when io_out_valid and io_out_ready.
  - io_out_valid = (count != 0).
  - io_out_rec is the head slot read combinationally from registered storage; zero latency from entry write to visibility on the next cycle.
  - On a fire: read pointer advances by 1, index increments (255 wraps to 0), io_retired increments.
- Minimum latency from input to output is 1 cycle.
- count_next = count + enq_num - deq. Simultaneous enqueue and dequeue are always legal, including when count = DEPTH - NUM_LANES.
- If any io_in_valid bit is set while io_in_ready=0:
  - nothing is written;
  - io_drop_err sets and holds until reset.
- io_flush=1:
  - next cycle count = 0 and pointers = 0;
  - enqueue and dequeue in that same cycle are suppressed;
  - index, io_retired and io_drop_err are kept.
- Reset asserted mid-operation clears all state immediately (asynchronously); in-flight records are discarded.
- The output record and index hold stable while io_out_valid=1 and io_out_ready=0.

Decomposition:
- Package difftest_commit_pkg:
  - REC_W.
  - Field offsets/widths, LSB first: instr 32, pc 64, wdest 8, wpdest 32, special 8, fpwen 1, rfwen 1, isRVC 1, skip 1.
  - Function rec_pc(), plus the other field extractors.
- One sub-module, difftest_commit_compact: combinational lane compaction producing per-lane slot offsets and the enqueue count (prefix popcount).
- FIFO storage and pointer logic stay in the top module.

Test Plan:
- Reset: assert io_reset mid-stream with 3 entries buffered -> immediately io_out_valid=0, io_out_index=0, io_retired=0, io_in_ready=1.
- Ordering: cycle0 lanes0/1 valid with pc 0x80000000/0x80000004, io_out_ready=1 -> outputs pc 0x80000000 index 0 at cycle1 and pc 0x80000004 index 1 at cycle2.
- Compaction: only lane1 valid (pc 0x1000) -> exactly one record out, pc 0x1000; count never exceeds 1.
- Backpressure: io_out_ready=0, push 2 records per cycle -> io_in_ready drops after count=8 (first at count 7? no: at count>6), i.e. ready=0 when count=8 with DEPTH=8; push while not ready -> io_drop_err=1 and stays 1; contents unchanged.
- Index wrap: dequeue 257 records -> indices 0..255,0; io_retired=257.
- Flush with simultaneous push: io_flush=1 with both lanes valid and 4 buffered -> next cycle io_out_valid=0, count 0, index unchanged.
